// File: rtl/meas_scheduler.sv
// Steps one shared high/low time-measurement core across four digital inputs and averages NAVG periods per channel.
// Latency: SETTLE cycles of core reset per channel, then up to one partial plus NAVG full periods; results come one cycle after REPORT.
// Backpressure: none; results are single-cycle pulses, and a start that arrives while busy is dropped.
module meas_scheduler #(
    parameter int          NAVG   = 4,
    parameter int          SETTLE = 8,
    parameter logic [19:0] TMO    = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic [3:0]  ch_en,
    input  logic [3:0]  digit_in,
    output logic        core_din,
    output logic        core_rst_n,
    input  logic [15:0] core_high,
    input  logic [15:0] core_low,
    output logic        busy,
    output logic        res_valid,
    output logic [1:0]  res_ch,
    output logic [15:0] res_high,
    output logic [15:0] res_low,
    output logic        res_err,
    output logic        scan_done
);

    localparam int SH = $clog2(NAVG);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NEXT    = 3'd1,
        S_SETTLE  = 3'd2,
        S_DISCARD = 3'd3,
        S_ACQ     = 3'd4,
        S_REPORT  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ch_en_q, ch_en_d;
    logic        cont_q, cont_d;
    logic [2:0]  nxt_q, nxt_d;
    logic [1:0]  sel_q, sel_d;
    logic        core_din_q, core_din_d;
    logic        din_d1_q, din_d1_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        fall_p_q, fall_p_d;
    logic        rise_p_q, rise_p_d;
    logic        hi_seen_q, hi_seen_d;
    logic [19:0] hsum_q, hsum_d;
    logic [19:0] lsum_q, lsum_d;
    logic [4:0]  per_q, per_d;
    logic [19:0] tmo_q, tmo_d;
    logic [15:0] set_q, set_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        res_valid_q, res_valid_d;
    logic [1:0]  res_ch_q, res_ch_d;
    logic [15:0] res_high_q, res_high_d;
    logic [15:0] res_low_q, res_low_d;
    logic        res_err_q, res_err_d;
    logic        scan_done_q, scan_done_d;

    logic        found;
    logic [1:0]  found_idx;
    logic        edge_rise, edge_fall, edge_any;
    logic        measuring;
    logic        timeout;
    logic        avg_done;
    logic        tmo_fire;

    assign edge_rise = core_din_q & ~din_d1_q;
    assign edge_fall = ~core_din_q & din_d1_q;
    assign edge_any  = edge_rise | edge_fall;
    assign measuring = (state_q == S_DISCARD) || (state_q == S_ACQ);
    // An edge in the same cycle as the limit keeps the channel alive.
    assign timeout   = measuring && !edge_any && (tmo_q >= (TMO - 20'd1));
    assign avg_done  = (state_q == S_ACQ) && rise_p_q && hi_seen_q
                       && (per_q == 5'(NAVG - 1));

    // Lowest enabled channel at or above the scan pointer.
    always_comb begin
        found     = 1'b0;
        found_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ch_en_q[i] && (3'(i) >= nxt_q)) begin
                found     = 1'b1;
                found_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ch_en_q      <= 4'd0;
            cont_q       <= 1'b0;
            nxt_q        <= 3'd0;
            sel_q        <= 2'd0;
            core_din_q   <= 1'b0;
            din_d1_q     <= 1'b0;
            core_rst_n_q <= 1'b0;
            fall_p_q     <= 1'b0;
            rise_p_q     <= 1'b0;
            hi_seen_q    <= 1'b0;
            hsum_q       <= 20'd0;
            lsum_q       <= 20'd0;
            per_q        <= 5'd0;
            tmo_q        <= 20'd0;
            set_q        <= 16'd0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_ch_q     <= 2'd0;
            res_high_q   <= 16'd0;
            res_low_q    <= 16'd0;
            res_err_q    <= 1'b0;
            scan_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_en_q      <= ch_en_d;
            cont_q       <= cont_d;
            nxt_q        <= nxt_d;
            sel_q        <= sel_d;
            core_din_q   <= core_din_d;
            din_d1_q     <= din_d1_d;
            core_rst_n_q <= core_rst_n_d;
            fall_p_q     <= fall_p_d;
            rise_p_q     <= rise_p_d;
            hi_seen_q    <= hi_seen_d;
            hsum_q       <= hsum_d;
            lsum_q       <= lsum_d;
            per_q        <= per_d;
            tmo_q        <= tmo_d;
            set_q        <= set_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
            res_ch_q     <= res_ch_d;
            res_high_q   <= res_high_d;
            res_low_q    <= res_low_d;
            res_err_q    <= res_err_d;
            scan_done_q  <= scan_done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmo_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (found)                state_d = S_SETTLE;
                else if (cont_q && cont)  state_d = S_NEXT;
                else                      state_d = S_IDLE;
            end
            S_SETTLE: begin
                if (set_q == 16'(SETTLE - 1)) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                if (edge_rise) begin
                    state_d = S_ACQ;
                end else if (timeout) begin
                    state_d  = S_REPORT;
                    tmo_fire = 1'b1;
                end
            end
            S_ACQ: begin
                if (avg_done) begin
                    state_d = S_REPORT;
                end else if (timeout) begin
                    state_d  = S_REPORT;
                    tmo_fire = 1'b1;
                end
            end
            S_REPORT: state_d = S_NEXT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ch_en_d      = ch_en_q;
        cont_d       = cont_q;
        nxt_d        = nxt_q;
        sel_d        = sel_q;
        core_din_d   = digit_in[sel_q];
        din_d1_d     = core_din_q;
        core_rst_n_d = (state_d != S_SETTLE);
        fall_p_d     = edge_fall;
        rise_p_d     = edge_rise;
        hi_seen_d    = hi_seen_q;
        hsum_d       = hsum_q;
        lsum_d       = lsum_q;
        per_d        = per_q;
        tmo_d        = tmo_q;
        set_d        = set_q;
        err_d        = err_q;
        res_valid_d  = 1'b0;
        res_ch_d     = res_ch_q;
        res_high_d   = res_high_q;
        res_low_d    = res_low_q;
        res_err_d    = res_err_q;
        scan_done_d  = 1'b0;

        if (state_q == S_IDLE && state_d == S_NEXT) begin
            ch_en_d = ch_en;
            cont_d  = cont;
            nxt_d   = 3'd0;
        end

        if (state_q == S_NEXT) begin
            if (found) begin
                sel_d  = found_idx;
                nxt_d  = {1'b0, found_idx} + 3'd1;
                hsum_d = 20'd0;
                lsum_d = 20'd0;
                per_d  = 5'd0;
                err_d  = 1'b0;
                set_d  = 16'd0;
            end else begin
                scan_done_d = 1'b1;
                cont_d      = cont;
                nxt_d       = 3'd0;
            end
        end

        if (state_q == S_SETTLE) begin
            set_d = set_q + 16'd1;
            if (state_d == S_DISCARD) begin
                tmo_d     = 20'd0;
                hi_seen_d = 1'b0;
            end
        end

        if (measuring) begin
            tmo_d = edge_any ? 20'd0 : tmo_q + 20'd1;
        end

        // The rise that ended DISCARD is captured in the first ACQ cycle and must not count.
        if (state_q == S_ACQ) begin
            if (fall_p_q) begin
                hsum_d    = hsum_q + {4'd0, core_high};
                hi_seen_d = 1'b1;
            end
            if (rise_p_q && hi_seen_q) begin
                lsum_d = lsum_q + {4'd0, core_low};
                per_d  = per_q + 5'd1;
            end
        end

        if (tmo_fire) err_d = 1'b1;

        if (state_q == S_REPORT) begin
            res_valid_d = 1'b1;
            res_ch_d    = sel_q;
            res_err_d   = err_q;
            res_high_d  = err_q ? 16'd0 : 16'(hsum_q >> SH);
            res_low_d   = err_q ? 16'd0 : 16'(lsum_q >> SH);
        end
    end

    // busy covers the scan_done cycle so a start there is still ignored.
    assign busy_d = (state_d != S_IDLE) || scan_done_d;

    assign core_din   = core_din_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign res_ch     = res_ch_q;
    assign res_high   = res_high_q;
    assign res_low    = res_low_q;
    assign res_err    = res_err_q;
    assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_meas_scheduler.sv
// Scoreboard bench for meas_scheduler: a behavioural measurement core and per-channel square-wave sources,
// expected results derived from the programmed waveform periods.
module tb_meas_scheduler;

    localparam int          NAVG   = 4;
    localparam int          SETTLE = 8;
    localparam logic [19:0] TMO    = 20'd200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [3:0]  ch_en = 4'd0;
    logic [3:0]  digit_in = 4'd0;
    logic [15:0] core_high = 16'd0;
    logic [15:0] core_low = 16'd0;
    logic        core_din, core_rst_n, busy, res_valid, res_err, scan_done;
    logic [1:0]  res_ch;
    logic [15:0] res_high, res_low;

    meas_scheduler #(.NAVG(NAVG), .SETTLE(SETTLE), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .ch_en(ch_en),
        .digit_in(digit_in), .core_din(core_din), .core_rst_n(core_rst_n),
        .core_high(core_high), .core_low(core_low), .busy(busy),
        .res_valid(res_valid), .res_ch(res_ch), .res_high(res_high),
        .res_low(res_low), .res_err(res_err), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int ch;
        int hi;
        int lo;
        bit err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;

    int p_hi[4];
    int p_lo[4];
    bit p_const[4];
    bit p_cval[4];
    bit p_jit[4];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: mean over NAVG periods; jitter alternates +0/+1 so the sum is exact.
    function automatic exp_t exp_for(input int ch);
        exp_t e;
        e.is_done = 1'b0;
        e.ch = ch;
        if (p_const[ch]) begin
            e.hi = 0; e.lo = 0; e.err = 1'b1;
        end else begin
            e.hi  = (p_hi[ch] * NAVG + (p_jit[ch] ? NAVG / 2 : 0)) / NAVG;
            e.lo  = (p_lo[ch] * NAVG + (p_jit[ch] ? NAVG / 2 : 0)) / NAVG;
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic push_scan(input logic [3:0] mask);
        exp_t d;
        for (int i = 0; i < 4; i++) if (mask[i]) q.push_back(exp_for(i));
        d.is_done = 1'b1; d.ch = 0; d.hi = 0; d.lo = 0; d.err = 1'b0;
        q.push_back(d);
    endtask

    task automatic set_sq(input int ch, input int hi, input int lo, input bit jit);
        p_const[ch] = 1'b0; p_hi[ch] = hi; p_lo[ch] = lo; p_jit[ch] = jit;
    endtask

    task automatic set_const(input int ch, input bit v);
        p_const[ch] = 1'b1; p_cval[ch] = v;
    endtask

    task automatic do_start(input logic [3:0] m, input bit c);
        @(negedge clk);
        ch_en = m; cont = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || q.size() != 0) && n < 20000);
        repeat (3) @(negedge clk);
        check({name, "_pending"}, q.size(), 0);
        check({name, "_busy"}, busy, 0);
        q.delete();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (res_valid || scan_done)) begin
                if (q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_output: res_valid=%0d ch=%0d scan_done=%0d, expected nothing",
                             res_valid, res_ch, scan_done);
                end else begin
                    e = q.pop_front();
                    check("event_is_done", scan_done, e.is_done);
                    if (!e.is_done && res_valid) begin
                        check("res_ch", res_ch, e.ch);
                        check("res_err", res_err, e.err);
                        check("res_high", res_high, e.hi);
                        check("res_low", res_low, e.lo);
                    end
                end
                if (scan_done) done_seen++;
            end
        end
    endtask

    task automatic gen();
        int cnt[4] = '{0, 0, 0, 0};
        bit lvl[4] = '{0, 0, 0, 0};
        bit alt_h[4] = '{0, 0, 0, 0};
        bit alt_l[4] = '{0, 0, 0, 0};
        int len;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (p_const[i]) begin
                    digit_in[i] = p_cval[i];
                end else begin
                    cnt[i]++;
                    len = lvl[i] ? p_hi[i] + int'(p_jit[i] && alt_h[i])
                                 : p_lo[i] + int'(p_jit[i] && alt_l[i]);
                    if (cnt[i] >= len) begin
                        if (lvl[i]) alt_h[i] = ~alt_h[i];
                        else        alt_l[i] = ~alt_l[i];
                        lvl[i] = ~lvl[i];
                        cnt[i] = 0;
                    end
                    digit_in[i] = lvl[i];
                end
            end
        end
    endtask

    // Behavioural core: on each level change, publish the length of the phase that just ended.
    task automatic core();
        bit p = 1'b0;
        int run = 0;
        forever begin
            @(negedge clk);
            if (!core_rst_n) begin
                run = 0; core_high = 16'd0; core_low = 16'd0; p = core_din;
            end else begin
                if (core_din != p) begin
                    if (p) core_high = 16'(run);
                    else   core_low  = 16'(run);
                    run = 1;
                end else begin
                    run++;
                end
                p = core_din;
            end
        end
    endtask

    task automatic stimulus();
        int n;
        logic [3:0] m;
        for (int i = 0; i < 4; i++) set_const(i, 1'b0);

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_core_din", core_din, 0);
        check("rst_res_high", res_high, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("core_rst_n_after_release", core_rst_n, 1);

        // Single channel, 10 high / 30 low.
        set_sq(0, 10, 30, 1'b0);
        push_scan(4'b0001);
        do_start(4'b0001, 1'b0);
        check("busy_after_start", busy, 1);
        wait_idle("ch0_10_30");

        // Two channels in ascending order; a second start mid-scan is ignored.
        set_sq(1, 5, 5, 1'b0);
        set_sq(3, 100, 20, 1'b0);
        push_scan(4'b1010);
        do_start(4'b1010, 1'b0);
        repeat (40) @(negedge clk);
        ch_en = 4'b1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ch1_ch3");

        // Stalled channel reports an error.
        set_const(2, 1'b1);
        push_scan(4'b0100);
        do_start(4'b0100, 1'b0);
        wait_idle("ch2_stall");

        // Empty mask: scan_done two cycles after start, no result.
        push_scan(4'b0000);
        @(negedge clk);
        ch_en = 4'b0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("empty_busy", busy, 1);
        check("empty_done_early", scan_done, 0);
        @(posedge clk);
        #1 check("empty_done_at_2", scan_done, 1);
        check("empty_no_result", res_valid, 0);
        wait_idle("empty");

        // Continuous mode: drop cont during the third scan.
        set_sq(0, 8, 8, 1'b0);
        for (int k = 0; k < 3; k++) push_scan(4'b0001);
        n = done_seen;
        do_start(4'b0001, 1'b1);
        begin
            int b = 0;
            while (done_seen < n + 2 && b < 20000) begin
                @(negedge clk);
                b++;
            end
        end
        cont = 1'b0;
        wait_idle("cont");
        check("cont_done_count", done_seen - n, 3);

        // Randomised scans.
        for (int it = 0; it < 8; it++) begin
            m = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) set_const(i, 1'($urandom_range(0, 1)));
                else set_sq(i, $urandom_range(2, 40), $urandom_range(2, 40), 1'($urandom_range(0, 1)));
            end
            push_scan(m);
            do_start(m, 1'b0);
            wait_idle("random");
        end

        // Reset in the middle of acquisition.
        set_sq(0, 40, 40, 1'b0);
        push_scan(4'b0001);
        do_start(4'b0001, 1'b0);
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_core_rst_n", core_rst_n, 0);
        check("midrst_core_din", core_din, 0);
        check("midrst_res_high", res_high, 0);
        check("midrst_res_low", res_low, 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_sq(0, 7, 13, 1'b1);
        push_scan(4'b0001);
        do_start(4'b0001, 1'b0);
        wait_idle("after_reset");
    endtask

    initial begin
        fork
            monitor();
            gen();
            core();
            stimulus();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/meas_scheduler.md
MEAS_SCHEDULER -- requirements
Module: meas_scheduler

Interface
REQ-001 Parameter: NAVG, default 4, number of full periods averaged per channel (power of two, 1..16).
REQ-002 Parameter: SETTLE, default 8, cycles that core_rst_n is held low after each channel switch (>=2).
REQ-003 Parameter: TMO, default 20'hFFFFF, cycles without a core_din edge before a channel is declared stalled.
REQ-004 Port: clk  in  1  system clock; all logic on posedge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  single-cycle pulse that begins one scan over the enabled channels.
REQ-007 Port: cont  in  1  sampled at start; 1 = rescan continuously until cont is sampled low at the end of a scan.
REQ-008 Port: ch_en  in  4  channel enable mask, sampled at start.
REQ-009 Port: digit_in  in  4  asynchronous-free digital inputs, one per channel, already synchronised.
REQ-010 Port: core_din  out  1  registered digit_in[sel]; feeds the shared high/low time-measurement core.
REQ-011 Port: core_rst_n  out  1  registered, active-low reset to the shared core.
REQ-012 Port: core_high  in  16  high-time count from the core.
REQ-013 Port: core_low  in  16  low-time count from the core.
REQ-014 Port: busy  out  1  high from the cycle after an accepted start until the cycle after scan_done.
REQ-015 Port: res_valid  out  1  one-cycle pulse; res_* are valid in that cycle and held until the next pulse.
REQ-016 Port: res_ch  out  2  channel index of the result.
REQ-017 Port: res_high  out  16  mean high time, in clk cycles.
REQ-018 Port: res_low  out  16  mean low time, in clk cycles.
REQ-019 Port: res_err  out  1  1 = channel stalled (timeout); res_high/res_low = 0.
REQ-020 Port: scan_done  out  1  one-cycle pulse after the last enabled channel of a scan.

Function
REQ-021 States: IDLE, NEXT, SETTLE, DISCARD, ACQ, REPORT; IDLE is the reset state.
REQ-022 IDLE: start with busy=0 latches ch_en and cont, then goes to NEXT; start while busy=1 is ignored.
REQ-023 NEXT: selects the lowest enabled channel above the current one, in ascending order 0..3; sel is set to that channel and the state goes to SETTLE.
REQ-024 NEXT with no remaining channel: pulses scan_done; if latched cont=1, cont is re-sampled and the scan restarts from channel 0; otherwise the state goes to IDLE.
REQ-025 Latched ch_en=0: scan_done pulses 2 cycles after start; no res_valid is produced.
REQ-026 SETTLE: core_rst_n=0 for exactly SETTLE cycles and core_din follows the new channel; the state then goes to DISCARD.
REQ-027 Edge detection uses an internal 1-cycle delayed copy of core_din; an edge detected in cycle t is captured from core_high (falling edge) or core_low (rising edge) in cycle t+1.
REQ-028 DISCARD: ignores counts until the first rising edge, then goes to ACQ, so that partial periods are never accumulated.
REQ-029 ACQ: a falling-edge capture adds core_high to the 20-bit hsum; the following rising-edge capture adds core_low to lsum and counts one period.
REQ-030 After NAVG periods the state goes to REPORT: res_high=hsum>>log2(NAVG) and res_low=lsum>>log2(NAVG), truncated, res_valid=1 for 1 cycle; the state then goes to NEXT.
REQ-031 Timeout counter: cleared on every detected edge and on entry to DISCARD; in DISCARD/ACQ, reaching TMO goes to REPORT with res_err=1 and results 0.
REQ-032 hsum, lsum and the period counter are cleared on entry to SETTLE.
REQ-033 An edge that is present at the same time as a timeout is treated as an edge, and no error is raised.
REQ-034 ch_en and digit_in changes during a scan do not alter the channel order of that scan.

Reset
REQ-035 rst_n low, at any time including mid-scan: state IDLE; busy, res_valid, scan_done, res_err, core_din = 0; core_rst_n = 0; res_ch, res_high, res_low, sums and counters = 0.
REQ-036 core_rst_n: 0 while rst_n is low; 1 from the first clk after reset release, except during SETTLE.

Verification
REQ-037 ch_en=4'b0001, ch0 square wave high 10 / low 30 cycles, start -> one res_valid: ch 0, high 10, low 30, err 0, then scan_done.
REQ-038 ch_en=4'b1010, ch1 high 5 / low 5, ch3 high 100 / low 20 -> results in order ch1 (5,5), then ch3 (100,20), then scan_done.
REQ-039 ch_en=4'b0100, ch2 held at constant 1 -> after about TMO cycles, res_valid with ch 2, err 1, high 0, low 0.
REQ-040 start pulsed again while busy; ch_en=0 with start -> the second start is ignored; with ch_en=0, scan_done arrives 2 cycles after start and no res_valid occurs.
REQ-041 cont=1, ch_en=4'b0001 -> repeated results and scan_done pulses; drive cont=0 -> busy falls after the current scan completes.
REQ-042 rst_n asserted during ACQ -> all outputs take reset values immediately; after release and a new start, the first result is correct.
